// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for alu_share_arbiter: NREQ packed request lanes in,
// one tagged result slot out.
interface alu_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*3-1:0]  req_op;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_data;
  logic [IDW-1:0]     resp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 32-bit ALU among NREQ requesters; the result lands in a
// single registered slot with backpressure, tagged with the winner's index.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus,
  output logic [31:0]         ops_done
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SRA = 3'd7
  } alu_op_e;

  function automatic logic [31:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                           input alu_op_e op);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [IDW-1:0] rr_ptr_q,     rr_ptr_d;
  logic           resp_valid_q, resp_valid_d;
  logic [31:0]    resp_data_q,  resp_data_d;
  logic [IDW-1:0] resp_id_q,    resp_id_d;
  logic [31:0]    ops_done_q,   ops_done_d;

  logic           slot_free;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  int             idx;

  // Scan from rr_ptr upward with wrap; the first valid lane wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    slot_free = !resp_valid_q || bus.resp_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
    // A held result or reset suppresses the grant entirely.
    grant_vld = grant_vld && slot_free && !rst;
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_vld) bus.req_ready = NREQ'(1) << grant_idx;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    ops_done_d   = ops_done_q;
    if (grant_vld) begin
      resp_valid_d = 1'b1;
      resp_data_d  = alu_eval(bus.req_a[32*grant_idx +: 32], bus.req_b[32*grant_idx +: 32],
                              alu_op_e'(bus.req_op[3*grant_idx +: 3]));
      resp_id_d    = grant_idx;
      rr_ptr_d     = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
      ops_done_d   = ops_done_q + 32'd1;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      ops_done_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign ops_done       = ops_done_q;

endmodule
